fifo_sc_prog_flags: RTL

FIFO_SC_PROG_FLAGS -- requirements
Module: fifo_sc_prog_flags

---
 rtl/fifo_sc_pkg.sv | 17 +
 rtl/fifo_sc_mem_array.sv | 34 +++
 rtl/fifo_sc_prog_flags.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_sc_pkg.sv
`default_nettype none
// ============================================================================
// fifo_sc_pkg : shared sizing constants and count-width rule for fifo_sc_*
// Revision    : 1.0
// ============================================================================
package fifo_sc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // One extra bit lets the occupancy count reach the full capacity value.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage : fifo_sc_pkg
`default_nettype wire

// File: rtl/fifo_sc_mem_array.sv
`default_nettype none
// ============================================================================
// fifo_sc_mem_array : storage, one synchronous write port, one async read port
// Revision          : 1.0
// ============================================================================
module fifo_sc_mem_array
  import fifo_sc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents are deliberately never reset; only pointers and count are.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_sc_mem_array
`default_nettype wire

// File: rtl/fifo_sc_prog_flags.sv
`default_nettype none
// ============================================================================
// fifo_sc_prog_flags : single-clock show-ahead FIFO with programmable flags
// Optional sticky overflow/underflow outputs under FIFO_SC_ERR_FLAGS_EN.
// Revision           : 1.0
// ============================================================================
module fifo_sc_prog_flags
  import fifo_sc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             wen,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             ren,
  input  logic [cnt_width(ADDR_WIDTH)-1:0] af_thresh,
  input  logic [cnt_width(ADDR_WIDTH)-1:0] ae_thresh,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [cnt_width(ADDR_WIDTH)-1:0] depth,
  output logic                             empty,
  output logic                             full,
  output logic                             almost_empty,
`ifdef FIFO_SC_ERR_FLAGS_EN
  output logic                             overflow,
  output logic                             underflow,
`endif
  output logic                             almost_full
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] CAPACITY = CW'(2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wrptr_q, wrptr_d;
  logic [ADDR_WIDTH-1:0] rdptr_q, rdptr_d;
  logic [CW-1:0]         depth_q, depth_d;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  mem_we;

  assign empty        = (depth_q == '0);
  assign full         = (depth_q == CAPACITY);
  assign almost_full  = (depth_q >= af_thresh);
  assign almost_empty = (depth_q <= ae_thresh);
  assign depth        = depth_q;

  assign wr_accept = wen & ~full;
  assign rd_accept = ren & ~empty;
  // Reset and flush both suppress the storage write so no stale entry lands.
  assign mem_we    = wr_accept & ~flush & ~reset;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    depth_d = depth_q;
    if (wr_accept) begin
      wrptr_d = wrptr_q + ADDR_WIDTH'(1);
    end
    if (rd_accept) begin
      rdptr_d = rdptr_q + ADDR_WIDTH'(1);
    end
    if (wr_accept && !rd_accept) begin
      depth_d = depth_q + CW'(1);
    end else if (rd_accept && !wr_accept) begin
      depth_d = depth_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      depth_q <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      depth_q <= depth_d;
    end
  end

  fifo_sc_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wrptr_q),
    .wdata_i (data_in),
    .raddr_i (rdptr_q),
    .rdata_o (data_out)
  );

`ifdef FIFO_SC_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wen & full);
    underflow_d = underflow_q | (ren & empty);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : fifo_sc_prog_flags
`default_nettype wire
